// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM generators and the PWM capture block:
//   - default clock / PWM frequency / samples-per-period parameters
//   - derived sample-tick divider (clocks per PWM sample)
//   - on_time / period widths and the capture FSM state type
// No ports; import with pwm_pkg::*.
// ---------------------------------------------------------------------------
package pwm_pkg;

  localparam int DEF_MAIN_FREQ   = 50_000_000;  // CLOCK_50, Hz
  localparam int DEF_PWM_FREQ    = 1000;        // nominal PWM frequency, Hz
  localparam int DEF_PWM_S_CNT   = 200;         // samples per nominal period
  localparam int DEF_TIMEOUT_SMP = 1000;        // samples without a rising edge

  localparam int ON_TIME_W   = 8;               // shared with the generators
  localparam int PERIOD_W    = 16;
  localparam int ON_TIME_MAX = (1 << ON_TIME_W) - 1;
  localparam int PERIOD_MAX  = (1 << PERIOD_W) - 1;

  // Clocks per PWM sample; never below 1 so a tick always exists.
  function automatic int calc_div(input int main_freq, input int pwm_freq,
                                  input int s_cnt);
    int d;
    d = main_freq / (pwm_freq * s_cnt);
    return (d < 1) ? 1 : d;
  endfunction

  localparam int SAMPLE_DIV = calc_div(DEF_MAIN_FREQ, DEF_PWM_FREQ, DEF_PWM_S_CNT);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STALL
  } cap_state_t;

endpackage

// File: rtl/pwm_in_conditioner.sv
// ---------------------------------------------------------------------------
// pwm_in_conditioner
// Brings the asynchronous PWM line into the clock domain and reduces it to
// one decision point per PWM sample.
//   clk     in  system clock
//   rst_n   in  synchronous reset, active low
//   pwm_in  in  asynchronous PWM line
//   tick    out one-clock pulse per PWM sample (prescaler wrap at DIV-1)
//   level   out sampled (optionally filtered) line level, valid with tick
//   rise    out rising edge of level (level 1, previous sample 0), with tick
// Build option: GLITCH_FILTER_EN enables a 3-tap majority vote over
// consecutive samples, rejecting single-sample glitches at the cost of one
// sample of edge latency.
// ---------------------------------------------------------------------------
module pwm_in_conditioner
  import pwm_pkg::*;
#(
  parameter int DIV = SAMPLE_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic tick,
  output logic level,
  output logic rise
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] WRAP = PW'(DIV - 1);

  logic          sync1, sync2;
  logic [PW-1:0] presc;
  logic          prev;
  logic          filt;

`ifdef GLITCH_FILTER_EN
  logic [1:0] hist;  // two previous raw samples, newest in bit 0
  assign filt = (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
`else
  assign filt = sync2;
`endif

  // Synchronizer, history and prev all reset to 1: a line that is already
  // high (or the flops' own reset value) must never look like a fresh edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      presc <= '0;
      prev  <= 1'b1;
      tick  <= 1'b0;
      level <= 1'b1;
      rise  <= 1'b0;
`ifdef GLITCH_FILTER_EN
      hist  <= 2'b11;
`endif
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge value of the others; blocking would collapse the 2-FF sync.
      sync1 <= pwm_in;
      sync2 <= sync1;
      tick  <= 1'b0;
      rise  <= 1'b0;
      if (presc == WRAP) begin
        presc <= '0;
        tick  <= 1'b1;
        level <= filt;
        rise  <= filt & ~prev;
        prev  <= filt;
`ifdef GLITCH_FILTER_EN
        hist  <= {hist[0], sync2};
`endif
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
// Measures an external PWM line and reports its high time (in PWM samples,
// same 0..PWM_S_CNT scale as the generators) and its period.
//   CLOCK_50  in   system clock
//   RESET_N   in   synchronous reset, active low
//   pwm_in    in   asynchronous PWM line
//   on_time   out  [7:0]  last high time in samples, saturates at 255
//   period    out  [15:0] last period in samples, saturates at 65535
//   valid     out  one-clock pulse when on_time/period update
//   stalled   out  level: no rising edge for TIMEOUT_SMP samples
// Build option: GLITCH_FILTER_EN (see pwm_in_conditioner).
// ---------------------------------------------------------------------------
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int MAIN_FREQ   = DEF_MAIN_FREQ,
  parameter int PWM_FREQ    = DEF_PWM_FREQ,
  parameter int PWM_S_CNT   = DEF_PWM_S_CNT,
  parameter int TIMEOUT_SMP = DEF_TIMEOUT_SMP
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic                 pwm_in,
  output logic [ON_TIME_W-1:0] on_time,
  output logic [PERIOD_W-1:0]  period,
  output logic                 valid,
  output logic                 stalled
);

  localparam int DIV = calc_div(MAIN_FREQ, PWM_FREQ, PWM_S_CNT);
  // on_time reported for a line stuck high: a full nominal period.
  localparam logic [ON_TIME_W-1:0] FULL_ON =
    ON_TIME_W'((PWM_S_CNT > ON_TIME_MAX) ? ON_TIME_MAX : PWM_S_CNT);
  localparam logic [PERIOD_W-1:0] TIMEOUT =
    PERIOD_W'((TIMEOUT_SMP > PERIOD_MAX) ? PERIOD_MAX : TIMEOUT_SMP);

  logic tick, level, rise;

  pwm_in_conditioner #(
    .DIV (DIV)
  ) u_cond (
    .clk    (CLOCK_50),
    .rst_n  (RESET_N),
    .pwm_in (pwm_in),
    .tick   (tick),
    .level  (level),
    .rise   (rise)
  );

  cap_state_t           state;
  logic [ON_TIME_W-1:0] high_cnt;
  logic [PERIOD_W-1:0]  per_cnt;
  logic [ON_TIME_W-1:0] high_inc;
  logic [PERIOD_W-1:0]  per_inc;
  logic [ON_TIME_W-1:0] stall_on;

  // Saturating next-count values; nothing ever wraps.
  assign per_inc  = (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;
  assign high_inc = (level && high_cnt != '1) ? high_cnt + 1'b1 : high_cnt;
  assign stall_on = level ? FULL_ON : '0;

  // Edge is tested before timeout in every state, so an edge on the
  // timeout tick wins. The edge sample is the first high sample of the
  // new period, hence counters restart at 1, not 0.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state    <= IDLE;
      high_cnt <= '0;
      per_cnt  <= '0;
      on_time  <= '0;
      period   <= '0;
      valid    <= 1'b0;
      stalled  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (rise) begin
              state    <= MEASURE;
              high_cnt <= ON_TIME_W'(1);
              per_cnt  <= PERIOD_W'(1);
            end else if (per_inc >= TIMEOUT) begin
              state   <= STALL;
              on_time <= stall_on;
              period  <= '0;
              valid   <= 1'b1;
              stalled <= 1'b1;
            end else begin
              per_cnt <= per_inc;
            end
          end
          MEASURE: begin
            if (rise) begin
              on_time  <= high_cnt;
              period   <= per_cnt;
              valid    <= 1'b1;
              stalled  <= 1'b0;
              high_cnt <= ON_TIME_W'(1);
              per_cnt  <= PERIOD_W'(1);
            end else if (per_inc >= TIMEOUT) begin
              state   <= STALL;
              on_time <= stall_on;
              period  <= '0;
              valid   <= 1'b1;
              stalled <= 1'b1;
            end else begin
              per_cnt  <= per_inc;
              high_cnt <= high_inc;
            end
          end
          STALL: begin
            // stalled stays up until the first full period is published.
            if (rise) begin
              state    <= MEASURE;
              high_cnt <= ON_TIME_W'(1);
              per_cnt  <= PERIOD_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
// Self-checking bench for pwm_capture. The line is driven one PWM sample at
// a time (each level held for DIV clocks). A reference model derives the
// expected publications from the sample stream using the measurement rules
// (edges, period = samples between edges, high time = high samples in the
// period, timeout after TIMEOUT_SMP samples). A monitor compares every
// valid pulse against the queue of expected publications.
// Honours GLITCH_FILTER_EN in the model.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

  localparam int MAIN_FREQ   = 400_000;  // gives 2 clocks per sample
  localparam int PWM_FREQ    = 1000;
  localparam int PWM_S_CNT   = 200;
  localparam int TIMEOUT_SMP = 1000;
  localparam int DIV         = MAIN_FREQ / (PWM_FREQ * PWM_S_CNT);

`ifdef GLITCH_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  localparam int MS_IDLE  = 0;
  localparam int MS_MEAS  = 1;
  localparam int MS_STALL = 2;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        pwm_in   = 1'b0;
  logic [7:0]  on_time;
  logic [15:0] period;
  logic        valid;
  logic        stalled;

  always #5 CLOCK_50 = ~CLOCK_50;

  pwm_capture #(
    .MAIN_FREQ   (MAIN_FREQ),
    .PWM_FREQ    (PWM_FREQ),
    .PWM_S_CNT   (PWM_S_CNT),
    .TIMEOUT_SMP (TIMEOUT_SMP)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .pwm_in   (pwm_in),
    .on_time  (on_time),
    .period   (period),
    .valid    (valid),
    .stalled  (stalled)
  );

  typedef struct {
    int on_t;
    int per;
    bit stl;
  } ev_t;

  ev_t exp_q[$];
  bit  stim[$];
  int  tests_run    = 0;
  int  tests_failed = 0;

  // Reference model state (reset together with the DUT).
  bit  m_f[$];     // filtered samples since reset
  bit  m_h1, m_h2; // previous two raw samples
  bit  m_prev;
  int  m_state;
  int  m_ep;       // sample index of the edge that opened the current period

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_f.delete();
    m_h1    = 1'b1;
    m_h2    = 1'b1;
    m_prev  = 1'b1;
    m_state = MS_IDLE;
    m_ep    = 0;
  endtask

  task automatic model_step(input bit raw);
    bit f, maj, rise;
    int i, ones;
    ev_t e;
    maj  = (raw & m_h1) | (raw & m_h2) | (m_h1 & m_h2);
    f    = FILTER_ON ? maj : raw;
    m_h2 = m_h1;
    m_h1 = raw;
    rise   = f & ~m_prev;
    m_prev = f;
    i = m_f.size();
    m_f.push_back(f);
    if (rise) begin
      if (m_state == MS_MEAS) begin
        ones = 0;
        for (int k = m_ep; k < i; k++) ones += int'(m_f[k]);
        e.on_t = (ones > 255) ? 255 : ones;
        e.per  = i - m_ep;
        e.stl  = 1'b0;
        exp_q.push_back(e);
      end
      m_state = MS_MEAS;
      m_ep    = i;
    end else if ((m_state == MS_MEAS && i - m_ep == TIMEOUT_SMP - 1) ||
                 (m_state == MS_IDLE && i == TIMEOUT_SMP - 1)) begin
      e.on_t  = f ? ((PWM_S_CNT > 255) ? 255 : PWM_S_CNT) : 0;
      e.per   = 0;
      e.stl   = 1'b1;
      exp_q.push_back(e);
      m_state = MS_STALL;
    end
  endtask

  task automatic add(input bit v, input int n);
    for (int k = 0; k < n; k++) stim.push_back(v);
  endtask

  // Model the queued stream, then drive it one sample per DIV clocks.
  task automatic play();
    foreach (stim[k]) model_step(stim[k]);
    foreach (stim[k]) begin
      pwm_in = stim[k];
      repeat (DIV) @(negedge CLOCK_50);
    end
    stim.delete();
  endtask

  task automatic do_reset(input int clocks, input bit lvl);
    @(negedge CLOCK_50);
    RESET_N = 1'b0;
    pwm_in  = lvl;
    repeat (clocks) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    model_reset();
  endtask

  task automatic drain(input string tag);
    repeat (8 * DIV) @(negedge CLOCK_50);
    check({tag, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_on_time"}, on_time, 0);
    check({tag, "_period"},  period,  0);
    check({tag, "_valid"},   valid,   0);
    check({tag, "_stalled"}, stalled, 0);
  endtask

  // Every valid pulse must match the next expected publication.
  ev_t got;
  always @(negedge CLOCK_50) begin
    if (RESET_N && valid) begin
      check("valid_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        check("on_time", on_time, got.on_t);
        check("period",  period,  got.per);
        check("stalled", stalled, got.stl);
      end
    end
  end

  initial begin
    int p, h;
    model_reset();

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    check_zero("reset");
    RESET_N = 1'b1;

    // 1: 50% duty at nominal period
    do_reset(2, 1'b0);
    add(0, 5);
    for (int k = 0; k < 4; k++) begin add(1, 100); add(0, 100); end
    add(1, 3); add(0, 8);
    play();
    drain("duty50");

    // 2: duty sweep 1 / 199 samples, then 0 (ends in stall, low level)
    do_reset(2, 1'b0);
    add(0, 5);
    for (int k = 0; k < 3; k++) begin add(1, 1);   add(0, 199); end
    for (int k = 0; k < 3; k++) begin add(1, 199); add(0, 1);   end
    add(1, 1); add(0, 1010);
    play();
    drain("sweep");

    // 3: line stuck high after lock, then recovery
    do_reset(2, 1'b0);
    add(0, 5);
    for (int k = 0; k < 3; k++) begin add(1, 100); add(0, 100); end
    add(1, 1100);
    play();
    check("stuck_stalled", stalled, 1);
    check("stuck_on_time", on_time, PWM_S_CNT);
    check("stuck_period",  period,  0);
    add(0, 100);
    for (int k = 0; k < 3; k++) begin add(1, 100); add(0, 100); end
    add(1, 3); add(0, 8);
    play();
    check("recover_stalled", stalled, 0);
    drain("stuck");

    // 4: 100 Hz 50% -- every period times out while high
    do_reset(2, 1'b0);
    add(0, 5);
    for (int k = 0; k < 2; k++) begin add(1, 1000); add(0, 1000); end
    add(0, 8);
    play();
    drain("slow");

    // High time above 255 samples saturates
    do_reset(2, 1'b0);
    add(0, 5);
    for (int k = 0; k < 3; k++) begin add(1, 300); add(0, 100); end
    add(1, 3); add(0, 8);
    play();
    drain("sat");

    // 5: single-sample glitch in the low phase
    do_reset(2, 1'b0);
    add(0, 5);
    for (int k = 0; k < 3; k++) begin
      add(1, 100); add(0, 30); add(1, 1); add(0, 69);
    end
    add(1, 3); add(0, 8);
    play();
    drain("glitch");

    // 6: one-clock reset in the middle of a high phase
    do_reset(2, 1'b0);
    add(0, 5);
    for (int k = 0; k < 3; k++) begin add(1, 100); add(0, 100); end
    add(1, 50);
    play();
    check("pre_reset_pending", exp_q.size(), 0);
    do_reset(1, 1'b1);
    check_zero("mid_reset");
    add(1, 50);
    for (int k = 0; k < 3; k++) begin add(0, 100); add(1, 100); end
    add(0, 8);
    play();
    drain("mid_reset");

    // Random periods and duties
    do_reset(2, 1'b0);
    add(0, 5);
    for (int k = 0; k < 8; k++) begin
      p = $urandom_range(600, 20);
      h = $urandom_range(p - 2, 2);
      add(1, h); add(0, p - h);
    end
    add(1, 3); add(0, 8);
    play();
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
